// File: rtl/iq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : iq_pkg
//  Purpose  : Shared sample type, LO phase / TX state encodings and the
//             saturating negate used by the quadrature mixer.
//  Revision : 1.0
// ============================================================================
package iq_pkg;

    localparam int unsigned c_SAMPLE_W = 5;

    typedef logic signed [c_SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } lo_phase_t;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_RUN  = 1'b1
    } tx_state_t;

    localparam sample_t c_SAMPLE_MIN = {1'b1, {(c_SAMPLE_W-1){1'b0}}};
    localparam sample_t c_SAMPLE_MAX = {1'b0, {(c_SAMPLE_W-1){1'b1}}};

    // The most negative code has no positive twin; clamp it to full scale.
    function automatic sample_t sat_neg(input sample_t x);
        if (x == c_SAMPLE_MIN) begin
            return c_SAMPLE_MAX;
        end
        return -x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iq_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : iq_tx_fifo
//  Purpose  : Synchronous FIFO holding one packed {I,Q} baseband pair per
//             entry; read data is the head entry, valid whenever !empty.
//  Revision : 1.0
// ============================================================================
module iq_tx_fifo #(
    parameter  int unsigned DATA_W = 10,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("iq_tx_fifo: DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_count == c_DEPTH);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/iq_mod_tx.sv
`default_nettype none
// ============================================================================
//  Module   : iq_mod_tx
//  Purpose  : fs/4 quadrature upconverter: buffers baseband I/Q and emits one
//             mixed IF sample per DAC request, with priming and underrun.
//  Revision : 1.0
// ============================================================================
module iq_mod_tx
    import iq_pkg::*;
#(
    parameter int unsigned W            = c_SAMPLE_W,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PRIME_LEVEL  = 2,
    parameter int unsigned IDLE_TIMEOUT = 8,
    parameter int unsigned UCNT_W       = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                bb_valid_i,
    output logic                bb_ready_o,
    input  logic signed [W-1:0] I_BB,
    input  logic signed [W-1:0] Q_BB,
    input  logic                DAC_rdy_i,
    output logic                mod_iq_valid,
    output logic signed [W-1:0] I_IF,
    output logic signed [W-1:0] Q_IF,
    output logic                underrun_o,
    output logic [UCNT_W-1:0]   underrun_cnt_o
);

    localparam int unsigned c_CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned c_IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0]  c_PRIME     = c_CNT_W'(PRIME_LEVEL);
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_TIMEOUT - 1);

    generate
        if (W != c_SAMPLE_W) begin : g_width_check
            $error("iq_mod_tx: W must match iq_pkg::c_SAMPLE_W");
        end
        if ((PRIME_LEVEL < 1) || (PRIME_LEVEL > FIFO_DEPTH)) begin : g_prime_check
            $error("iq_mod_tx: PRIME_LEVEL must be in 1..FIFO_DEPTH");
        end
        if (IDLE_TIMEOUT < 1) begin : g_timeout_check
            $error("iq_mod_tx: IDLE_TIMEOUT must be >= 1");
        end
    endgenerate

    tx_state_t           r_state;
    lo_phase_t           r_phase;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                r_valid;
    sample_t             r_i_if;
    sample_t             r_q_if;
    logic                r_underrun;
    logic [UCNT_W-1:0]   r_ucnt;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [c_CNT_W-1:0]  w_count;
    logic [2*W-1:0]      w_fifo_dout;
    sample_t             w_bb_i;
    sample_t             w_bb_q;
    sample_t             w_mix_i;
    sample_t             w_mix_q;

    assign bb_ready_o = !w_full;
    assign w_push     = bb_valid_i && !w_full;
    // Pops only happen on a DAC request in RUN; requests in IDLE are dropped.
    assign w_pop      = (r_state == TX_RUN) && DAC_rdy_i && !w_empty;

    iq_tx_fifo #(
        .DATA_W (2 * W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (w_push),
        .push_data ({I_BB, Q_BB}),
        .pop       (w_pop),
        .pop_data  (w_fifo_dout),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    // An underrun mixes the zero sample so the LO keeps running coherently.
    assign w_bb_i = w_empty ? '0 : sample_t'(w_fifo_dout[2*W-1:W]);
    assign w_bb_q = w_empty ? '0 : sample_t'(w_fifo_dout[W-1:0]);

    always_comb begin
        w_mix_i = w_bb_i;
        w_mix_q = w_bb_q;
        case (r_phase)
            PH0: begin
                w_mix_i = w_bb_i;
                w_mix_q = w_bb_q;
            end
            PH1: begin
                w_mix_i = sat_neg(w_bb_q);
                w_mix_q = w_bb_i;
            end
            PH2: begin
                w_mix_i = sat_neg(w_bb_i);
                w_mix_q = sat_neg(w_bb_q);
            end
            PH3: begin
                w_mix_i = w_bb_q;
                w_mix_q = sat_neg(w_bb_i);
            end
            default: begin
                w_mix_i = '0;
                w_mix_q = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= TX_IDLE;
            r_phase    <= PH0;
            r_idle_cnt <= '0;
            r_valid    <= 1'b0;
            r_i_if     <= '0;
            r_q_if     <= '0;
            r_underrun <= 1'b0;
            r_ucnt     <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                TX_IDLE: begin
                    r_phase    <= PH0;
                    r_idle_cnt <= '0;
                    if (w_count >= c_PRIME) begin
                        r_state    <= TX_RUN;
                        r_underrun <= 1'b0;
                    end
                end
                TX_RUN: begin
                    if (DAC_rdy_i) begin
                        r_valid <= 1'b1;
                        r_i_if  <= w_mix_i;
                        r_q_if  <= w_mix_q;
                        r_phase <= lo_phase_t'(r_phase + 2'd1);
                        if (!w_empty) begin
                            r_idle_cnt <= '0;
                        end else begin
                            r_underrun <= 1'b1;
                            if (r_ucnt != '1) begin
                                r_ucnt <= r_ucnt + 1'b1;
                            end
                            if (r_idle_cnt == c_IDLE_LAST) begin
                                r_state    <= TX_IDLE;
                                r_phase    <= PH0;
                                r_idle_cnt <= '0;
                            end else begin
                                r_idle_cnt <= r_idle_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= TX_IDLE;
            endcase
        end
    end

    assign mod_iq_valid   = r_valid;
    assign I_IF           = r_i_if;
    assign Q_IF           = r_q_if;
    assign underrun_o     = r_underrun;
    assign underrun_cnt_o = r_ucnt;

endmodule
`default_nettype wire
